// File: rtl/macfp32_dot_seq.sv
// Dot-product sequencer around an external FP32 multiply-add unit.
// Takes a command (length, initial accumulator) and pulls operand pairs one
// at a time. Each pair is issued to the MAC with the running accumulator on
// in_c. The MAC result is written back after MAC_LAT cycles, and the final
// sum is returned on the result port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// FETCH | waiting for an operand pair; op_ready high
// WAIT  | MAC operation in flight; counts down to the mac_out sample edge
// DONE  | result presented on res_data; res_valid high until res_ready

module macfp32_dot_seq #(
    parameter int BIT_WIDTH = 32,
    parameter int LEN_WIDTH = 16,
    parameter int MAC_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [BIT_WIDTH-1:0] cmd_init,

    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [BIT_WIDTH-1:0] op_a,
    input  logic [BIT_WIDTH-1:0] op_b,

    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BIT_WIDTH-1:0] res_data,

    output logic                 busy,

    output logic [BIT_WIDTH-1:0] mac_a,
    output logic [BIT_WIDTH-1:0] mac_b,
    output logic [BIT_WIDTH-1:0] mac_c,
    input  logic [BIT_WIDTH-1:0] mac_out
);

    // A one-bit counter is kept even for MAC_LAT=1 so the counter logic
    // stays the same shape for every latency. In that case it only ever
    // holds 0.
    localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAC_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [BIT_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0] remaining;
    logic [CNT_W-1:0]     wait_cnt;

    logic                 wait_done;
    logic                 last_op;

    assign wait_done = (wait_cnt == '0);
    assign last_op   = (remaining == LEN_WIDTH'(1));

    // Result is the accumulator itself. It is stable in DONE because
    // nothing writes acc there.
    assign res_data = acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end

            FETCH: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (wait_done) begin
                    if (last_op) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end

            DONE: begin
                // Returning to IDLE here means a command can only be taken
                // on the cycle after the result handshake.
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator, pair counter and MAC latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        acc       <= cmd_init;
                        remaining <= cmd_len;
                    end
                end

                FETCH: begin
                    if (op_valid) begin
                        wait_cnt <= CNT_LOAD;
                    end
                end

                WAIT: begin
                    if (!wait_done) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else begin
                        acc <= mac_out;
                        // WAIT is only entered with remaining >= 1. The guard
                        // keeps the counter from wrapping if that ever fails.
                        if (remaining != '0) begin
                            remaining <= remaining - LEN_WIDTH'(1);
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // MAC input registers: loaded only on an operand handshake, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_a <= '0;
            mac_b <= '0;
            mac_c <= '0;
        end else if (state == FETCH && op_valid) begin
            mac_a <= op_a;
            mac_b <= op_b;
            mac_c <= acc;
        end
    end

endmodule

// File: tb/tb_macfp32_dot_seq.sv
// Bench for macfp32_dot_seq. There are two instances: MAC_LAT=1 with a
// combinational MAC model, and MAC_LAT=3 with a two-stage pipelined MAC model.
// The sel signal routes the shared stimulus to one instance and picks which
// instance's outputs are observed. The MAC model handles FP32 values that
// hold non-negative integers below 2^24, and does that arithmetic exactly.
module tb_macfp32_dot_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;

    logic        cmd_valid;
    logic [15:0] cmd_len;
    logic [31:0] cmd_init;
    logic        op_valid;
    logic [31:0] op_a, op_b;
    logic        res_ready;

    logic        cmd_valid1, op_valid1, res_ready1;
    logic        cmd_ready1, op_ready1, res_valid1, busy1;
    logic [31:0] res_data1, mac_a1, mac_b1, mac_c1, mac_out1;

    logic        cmd_valid3, op_valid3, res_ready3;
    logic        cmd_ready3, op_ready3, res_valid3, busy3;
    logic [31:0] res_data3, mac_a3, mac_b3, mac_c3, mac_out3;
    logic [31:0] pipe1, pipe2;

    logic        cmd_ready, op_ready, res_valid, busy;
    logic [31:0] res_data, mac_a, mac_b, mac_c;

    int checks = 0;
    int errors = 0;

    int unsigned ia [64];
    int unsigned ib [64];
    logic [31:0] va [64];
    logic [31:0] vb [64];
    int          hs_cyc [64];
    logic [31:0] mc_log [64];
    logic [31:0] ma_log [64];

    always #5 clk = ~clk;

    function automatic logic [31:0] int2fp(input int unsigned v);
        int          e;
        int unsigned sh;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if (v[i]) e = i;
        sh = v << (23 - e);
        r = {1'b0, 8'(127 + e), sh[22:0]};
        return r;
    endfunction

    function automatic int unsigned fp2int(input logic [31:0] f);
        int          e;
        int unsigned m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {9'h1, f[22:0]};
        return m >> (23 - e);
    endfunction

    function automatic logic [31:0] fp_mac(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        return int2fp(fp2int(a) * fp2int(b) + fp2int(c));
    endfunction

    assign cmd_valid1 = cmd_valid & ~sel;
    assign op_valid1  = op_valid  & ~sel;
    assign res_ready1 = res_ready & ~sel;
    assign cmd_valid3 = cmd_valid & sel;
    assign op_valid3  = op_valid  & sel;
    assign res_ready3 = res_ready & sel;

    assign cmd_ready = sel ? cmd_ready3 : cmd_ready1;
    assign op_ready  = sel ? op_ready3  : op_ready1;
    assign res_valid = sel ? res_valid3 : res_valid1;
    assign res_data  = sel ? res_data3  : res_data1;
    assign busy      = sel ? busy3      : busy1;
    assign mac_a     = sel ? mac_a3     : mac_a1;
    assign mac_b     = sel ? mac_b3     : mac_b1;
    assign mac_c     = sel ? mac_c3     : mac_c1;

    assign mac_out1 = fp_mac(mac_a1, mac_b1, mac_c1);

    always @(posedge clk) begin
        pipe1 <= fp_mac(mac_a3, mac_b3, mac_c3);
        pipe2 <= pipe1;
    end
    assign mac_out3 = pipe2;

    macfp32_dot_seq #(.BIT_WIDTH(32), .LEN_WIDTH(16), .MAC_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_len(cmd_len), .cmd_init(cmd_init),
        .op_valid(op_valid1), .op_ready(op_ready1), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1),
        .busy(busy1),
        .mac_a(mac_a1), .mac_b(mac_b1), .mac_c(mac_c1), .mac_out(mac_out1)
    );

    macfp32_dot_seq #(.BIT_WIDTH(32), .LEN_WIDTH(16), .MAC_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_len(cmd_len), .cmd_init(cmd_init),
        .op_valid(op_valid3), .op_ready(op_ready3), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
        .busy(busy3),
        .mac_a(mac_a3), .mac_b(mac_b3), .mac_c(mac_c3), .mac_out(mac_out3)
    );

    // Runs one command on the selected instance. Must be entered #1 after a
    // clock edge. Cycle 1 is the cycle right after the command handshake
    // edge. Operand handshake cycles and the MAC inputs seen just after each
    // issue are logged. Returns #1 after the result handshake edge.
    task automatic run(input int len, input logic [31:0] init, input int ostall,
                       input int rstall, input bit junk,
                       output logic [31:0] result, output int lat, output int nops,
                       output bit opr_seen, output bit stable_ok, output bit crdy_ok,
                       output bit timeout);
        int          cyc, gap, dcnt;
        bit          hs_op, hs_res;
        logic [31:0] first;
        crdy_ok   = (cmd_ready === 1'b1);
        cmd_len   = 16'(len);
        cmd_init  = init;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1; gap = 0; dcnt = 0; nops = 0; lat = -1;
        opr_seen = 0; stable_ok = 1; timeout = 1;
        result = 32'h0; first = 32'h0;
        while (cyc < 3000) begin
            if (op_ready === 1'b1) opr_seen = 1;
            if (res_valid === 1'b1) begin
                if (lat < 0) begin
                    lat = cyc;
                    first = res_data;
                end else if (res_data !== first) begin
                    stable_ok = 0;
                end
                if (cmd_ready !== 1'b0) crdy_ok = 0;
            end
            op_valid = ((nops < len) && (gap >= ostall)) || (junk && res_valid === 1'b1);
            op_a = va[nops % 64] ^ (junk && nops >= len ? 32'h1234 : 32'h0);
            op_b = vb[nops % 64];
            if (op_ready === 1'b1 && !op_valid) gap++;
            res_ready = (res_valid === 1'b1) && (dcnt >= rstall);
            if (res_valid === 1'b1) dcnt++;
            cmd_valid = junk && (cmd_ready === 1'b0);
            cmd_len   = 16'h0;
            cmd_init  = 32'hDEADBEEF;
            hs_op  = op_valid && (op_ready === 1'b1);
            hs_res = res_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs_op) begin
                if (nops < 64) begin
                    hs_cyc[nops] = cyc;
                    mc_log[nops] = mac_c;
                    ma_log[nops] = mac_a;
                end
                nops++;
                gap = 0;
            end
            if (hs_res) begin
                result  = first;
                timeout = 0;
                if (cmd_ready !== 1'b1) crdy_ok = 0;
                break;
            end
        end
        op_valid = 1'b0; res_ready = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({cmd_ready1, op_ready1, res_valid1, busy1} !== 4'b1000) begin errors++;
            $display("FAIL reset_ctrl1 got %b want 1000", {cmd_ready1, op_ready1, res_valid1, busy1}); end
        checks++; if ({cmd_ready3, op_ready3, res_valid3, busy3} !== 4'b1000) begin errors++;
            $display("FAIL reset_ctrl3 got %b want 1000", {cmd_ready3, op_ready3, res_valid3, busy3}); end
        checks++; if ({res_data1, mac_a1, mac_b1, mac_c1} !== 128'h0) begin errors++;
            $display("FAIL reset_data1 got %h %h %h %h want 0", res_data1, mac_a1, mac_b1, mac_c1); end
        checks++; if ({res_data3, mac_a3, mac_b3, mac_c3} !== 128'h0) begin errors++;
            $display("FAIL reset_data3 got %h %h %h %h want 0", res_data3, mac_a3, mac_b3, mac_c3); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] r; int lat, nops; bit opr, st, cr, to;
        sel = 1'b0;
        va[0] = 32'h3F800000; vb[0] = 32'h40400000;
        va[1] = 32'h40000000; vb[1] = 32'h40800000;
        run(2, 32'h0, 0, 0, 0, r, lat, nops, opr, st, cr, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got %0d want 0", to); end
        checks++; if (r !== 32'h41300000) begin errors++; $display("FAIL basic_result got %h want 41300000", r); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        checks++; if (hs_cyc[1] - hs_cyc[0] !== 2) begin errors++;
            $display("FAIL basic_op_spacing got %0d want 2", hs_cyc[1] - hs_cyc[0]); end
        checks++; if (mc_log[1] !== 32'h40400000) begin errors++;
            $display("FAIL basic_mac_c got %h want 40400000", mc_log[1]); end
        checks++; if (res_valid !== 1'b0) begin errors++;
            $display("FAIL basic_valid_one_cycle got %b want 0", res_valid); end
        checks++; if (cr !== 1'b1) begin errors++; $display("FAIL basic_cmd_ready got %0d want 1", cr); end
    endtask

    task automatic test_zero_len();
        logic [31:0] r; int lat, nops; bit opr, st, cr, to;
        sel = 1'b0;
        run(0, 32'h3F800000, 0, 0, 0, r, lat, nops, opr, st, cr, to);
        checks++; if (r !== 32'h3F800000 || to) begin errors++;
            $display("FAIL zero_result got %h to=%0d want 3f800000", r, to); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
        checks++; if (opr !== 1'b0 || nops !== 0) begin errors++;
            $display("FAIL zero_op_ready got seen=%0d nops=%0d want 0 0", opr, nops); end
    endtask

    task automatic test_stalls();
        logic [31:0] r; int lat, nops; bit opr, st, cr, to;
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin va[i] = 32'h3F800000; vb[i] = 32'h3F800000; end
        run(3, 32'h0, 3, 4, 0, r, lat, nops, opr, st, cr, to);
        checks++; if (r !== 32'h40400000 || to) begin errors++;
            $display("FAIL stall_result got %h to=%0d want 40400000", r, to); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL stall_latency got %0d want 16", lat); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_res_stable got %0d want 1", st); end
        checks++; if (cr !== 1'b1) begin errors++; $display("FAIL stall_cmd_ready got %0d want 1", cr); end
        checks++; if (nops !== 3) begin errors++; $display("FAIL stall_nops got %0d want 3", nops); end
    endtask

    task automatic test_mac_lat3();
        logic [31:0] r; int lat, nops; bit opr, st, cr, to;
        sel = 1'b1;
        va[0] = 32'h3F800000; vb[0] = 32'h40400000;
        va[1] = 32'h40000000; vb[1] = 32'h40800000;
        run(2, 32'h0, 0, 0, 0, r, lat, nops, opr, st, cr, to);
        checks++; if (r !== 32'h41300000 || to) begin errors++;
            $display("FAIL lat3_result got %h to=%0d want 41300000", r, to); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL lat3_latency got %0d want 9", lat); end
        checks++; if (hs_cyc[1] - hs_cyc[0] !== 4) begin errors++;
            $display("FAIL lat3_op_spacing got %0d want 4", hs_cyc[1] - hs_cyc[0]); end
        checks++; if (mc_log[0] !== 32'h0 || mc_log[1] !== 32'h40400000) begin errors++;
            $display("FAIL lat3_mac_c got %h %h want 0 40400000", mc_log[0], mc_log[1]); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int lat, nops; bit opr, st, cr, to; bit seen;
        sel = 1'b0;
        cmd_len = 16'd3; cmd_init = int2fp(5); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = int2fp(2); op_b = int2fp(3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        op_a = int2fp(4); op_b = int2fp(1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        checks++; if ({busy, op_ready, res_valid} !== 3'b100) begin errors++;
            $display("FAIL rstmid_in_wait got %b want 100", {busy, op_ready, res_valid}); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({cmd_ready, busy, op_ready, res_valid} !== 4'b1000) begin errors++;
            $display("FAIL rstmid_ctrl got %b want 1000", {cmd_ready, busy, op_ready, res_valid}); end
        checks++; if ({res_data, mac_a, mac_b, mac_c} !== 128'h0) begin errors++;
            $display("FAIL rstmid_data got %h %h %h %h want 0", res_data, mac_a, mac_b, mac_c); end
        seen = 0;
        repeat (6) begin
            if (res_valid !== 1'b0) seen = 1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_result got %0d want 0", seen); end
        va[0] = 32'h40000000; vb[0] = 32'h40000000;
        run(1, 32'h0, 0, 0, 0, r, lat, nops, opr, st, cr, to);
        checks++; if (r !== 32'h40800000 || to) begin errors++;
            $display("FAIL rstmid_rerun got %h to=%0d want 40800000", r, to); end
    endtask

    task automatic test_illegal();
        logic [31:0] r; int lat, nops; bit opr, st, cr, to; bit took;
        logic [31:0] ma_before;
        sel = 1'b0;
        ma_before = mac_a;
        took = 0;
        op_valid = 1'b1; op_a = 32'h4B000000; op_b = 32'h4B000000;
        repeat (3) begin
            if (op_ready !== 1'b0) took = 1;
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        checks++; if (took !== 1'b0 || mac_a !== ma_before) begin errors++;
            $display("FAIL illegal_idle_op got ready=%0d mac_a=%h want 0 %h", took, mac_a, ma_before); end
        ia[0] = 3; ib[0] = 5; ia[1] = 7; ib[1] = 2;
        for (int i = 0; i < 2; i++) begin va[i] = int2fp(ia[i]); vb[i] = int2fp(ib[i]); end
        run(2, int2fp(1), 1, 3, 1, r, lat, nops, opr, st, cr, to);
        checks++; if (r !== int2fp(1 + 15 + 14) || to) begin errors++;
            $display("FAIL illegal_result got %h to=%0d want %h", r, to, int2fp(30)); end
        checks++; if (nops !== 2 || mac_a !== va[1]) begin errors++;
            $display("FAIL illegal_done_op got nops=%0d mac_a=%h want 2 %h", nops, mac_a, va[1]); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || cr !== 1'b1) begin errors++;
            $display("FAIL illegal_cmd got busy=%b ready=%b cr=%0d want 0 1 1", busy, cmd_ready, cr); end
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] r; int lat, nops; bit opr, st, cr, to;
        int len, ost, rst_st, lat_m; int unsigned init, acc;
        for (int n = 0; n < 16; n++) begin
            sel    = 1'($urandom_range(0, 1));
            lat_m  = sel ? 3 : 1;
            len    = $urandom_range(0, 6);
            init   = $urandom_range(0, 50);
            ost    = $urandom_range(0, 2);
            rst_st = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) begin
                ia[i] = $urandom_range(0, 15); ib[i] = $urandom_range(0, 15);
                va[i] = int2fp(ia[i]); vb[i] = int2fp(ib[i]);
            end
            run(len, int2fp(init), ost, rst_st, 1'($urandom_range(0, 1)),
                r, lat, nops, opr, st, cr, to);
            acc = init;
            for (int i = 0; i < len; i++) begin
                checks++; if (mc_log[i] !== int2fp(acc) || ma_log[i] !== va[i]) begin errors++;
                    $display("FAIL rand_issue n=%0d op=%0d got c=%h a=%h want c=%h a=%h",
                             n, i, mc_log[i], ma_log[i], int2fp(acc), va[i]); end
                acc += ia[i] * ib[i];
            end
            checks++; if (r !== int2fp(acc) || to || nops !== len) begin errors++;
                $display("FAIL rand_result n=%0d got %h nops=%0d to=%0d want %h nops=%0d",
                         n, r, nops, to, int2fp(acc), len); end
            checks++; if (st !== 1'b1 || cr !== 1'b1) begin errors++;
                $display("FAIL rand_handshake n=%0d got stable=%0d cmd_ready=%0d want 1 1", n, st, cr); end
            if (ost == 0) begin
                checks++; if (lat !== len * (lat_m + 1) + 1) begin errors++;
                    $display("FAIL rand_latency n=%0d got %0d want %0d", n, lat, len * (lat_m + 1) + 1); end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1;
        cmd_valid = 1'b0; cmd_len = 16'h0; cmd_init = 32'h0;
        op_valid = 1'b0; op_a = 32'h0; op_b = 32'h0; res_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_stalls();
        test_mac_lat3();
        test_reset_mid();
        test_illegal();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
